wave_frame_fifo: RTL and testbench

Parametrised frame-oriented FIFO that buffers complete ultrasonic wave captures between the sampling front end and the upload path. It generalises the fixed-geometry wave buffer to configurable sample width, slot size and slot count. It latches a per-frame length so consecutive waves may differ in size. It adds frame commit/abort, an end-of-frame read marker and a committed-frame count.

---
 rtl/wave_frame_fifo.sv | 184 ++++++++++++++++++
 tb/tb_wave_frame_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_frame_fifo.sv
// wave_frame_fifo: frame-oriented FIFO for ultrasonic wave captures.
// Memory is split into 2^NL slots of 2^SW samples. A frame is written into
// the current write slot and becomes visible to the reader only once its
// last sample is stored. A per-slot size table remembers each frame length.
//
// Parameters:
//   DW  sample width
//   SW  log2 slot depth (max frame = 2^SW samples)
//   NL  log2 slot count
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_frame_size_dec    frame length - 1, latched on the first word of a frame
//   i_wr, i_wave_data   write request and sample
//   i_wr_abort          discard the partially written frame
//   i_rd                read request
//   o_wave_data         read sample (one cycle after an accepted read)
//   o_rd_effect         o_wave_data updated this cycle
//   o_rd_last           o_wave_data is the final sample of its frame
//   o_full, o_empty     all slots committed / nothing committed
//   o_frame_cnt         committed frames not yet fully read
// Build option:
//   WAVE_FRAME_FIFO_ABORT_EN  enables i_wr_abort; otherwise the pin is ignored.
module wave_frame_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 12,
    parameter int unsigned NL = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [SW-1:0] i_frame_size_dec,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wave_data,
    input  logic          i_wr_abort,
    input  logic          i_rd,
    output logic [DW-1:0] o_wave_data,
    output logic          o_rd_effect,
    output logic          o_rd_last,
    output logic          o_full,
    output logic          o_empty,
    output logic [NL:0]   o_frame_cnt
);

    localparam int unsigned SLOTS = 1 << NL;
    localparam int unsigned AW    = NL + SW;
    localparam int unsigned DEPTH = 1 << AW;

    // Storage
    logic [DW-1:0] mem [DEPTH];
    logic [SW-1:0] size_tbl_q [SLOTS];

    // Pointer / status registers
    logic [NL-1:0] wr_idx_q,  wr_idx_d;
    logic [SW-1:0] wr_size_q, wr_size_d;
    logic [NL-1:0] rd_idx_q,  rd_idx_d;
    logic [SW-1:0] rd_size_q, rd_size_d;
    logic [NL:0]   cnt_q,     cnt_d;
    logic          full_q,    full_d;
    logic          empty_q,   empty_d;
    logic [DW-1:0] rdata_q;
    logic          rd_effect_q, rd_last_q;

    // Handshake decode
    logic          abort_c;
    logic          wr_acc_c;
    logic          commit_c;
    logic          rd_acc_c;
    logic          release_c;
    logic [SW-1:0] wr_lim_c;
    logic [SW-1:0] rd_lim_c;
    logic [AW-1:0] wr_addr_c;
    logic [AW-1:0] rd_addr_c;

`ifdef WAVE_FRAME_FIFO_ABORT_EN
    // An abort only matters while a frame is partially written.
    assign abort_c = i_wr_abort & (wr_size_q != '0);
`else
    logic unused_abort;
    assign unused_abort = i_wr_abort;
    assign abort_c      = 1'b0;
`endif

    // First word of a frame compares against the live size input, later
    // words against the value latched into the size table.
    assign wr_lim_c  = (wr_size_q == '0) ? i_frame_size_dec : size_tbl_q[wr_idx_q];
    assign wr_acc_c  = i_wr & ~full_q & ~abort_c;
    assign commit_c  = wr_acc_c & (wr_size_q == wr_lim_c);
    assign wr_addr_c = {wr_idx_q, wr_size_q};

    // The reader only ever points at committed slots, so the size table
    // entry it uses is never being rewritten at the same time.
    assign rd_lim_c  = size_tbl_q[rd_idx_q];
    assign rd_acc_c  = i_rd & ~empty_q;
    assign release_c = rd_acc_c & (rd_size_q == rd_lim_c);
    assign rd_addr_c = {rd_idx_q, rd_size_q};

    // Next-state logic for pointers and frame count
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_size_d = wr_size_q;
        rd_idx_d  = rd_idx_q;
        rd_size_d = rd_size_q;
        cnt_d     = cnt_q;

        if (abort_c) begin
            wr_size_d = '0;
        end else if (commit_c) begin
            wr_size_d = '0;
            wr_idx_d  = wr_idx_q + NL'(1);
        end else if (wr_acc_c) begin
            wr_size_d = wr_size_q + SW'(1);
        end

        if (release_c) begin
            rd_size_d = '0;
            rd_idx_d  = rd_idx_q + NL'(1);
        end else if (rd_acc_c) begin
            rd_size_d = rd_size_q + SW'(1);
        end

        unique case ({commit_c, release_c})
            2'b10:   cnt_d = cnt_q + (NL+1)'(1);
            2'b01:   cnt_d = cnt_q - (NL+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        full_d  = (cnt_d == (NL+1)'(SLOTS));
        empty_d = (cnt_d == '0);
    end

    // Pointer, count and read-port registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_idx_q    <= '0;
            wr_size_q   <= '0;
            rd_idx_q    <= '0;
            rd_size_q   <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            rdata_q     <= '0;
            rd_effect_q <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            wr_size_q   <= wr_size_d;
            rd_idx_q    <= rd_idx_d;
            rd_size_q   <= rd_size_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            rd_effect_q <= rd_acc_c;
            rd_last_q   <= release_c;
            if (rd_acc_c) begin
                rdata_q <= mem[rd_addr_c];
            end
        end
    end

    // Frame length latch, written on the first accepted word of each frame
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                size_tbl_q[i] <= '0;
            end
        end else if (wr_acc_c && (wr_size_q == '0)) begin
            size_tbl_q[wr_idx_q] <= i_frame_size_dec;
        end
    end

    // Sample memory, intentionally not cleared by reset
    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_acc_c) begin
            mem[wr_addr_c] <= i_wave_data;
        end
    end

    assign o_wave_data = rdata_q;
    assign o_rd_effect = rd_effect_q;
    assign o_rd_last   = rd_last_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_wave_frame_fifo.sv
// Directed bench for wave_frame_fifo with default parameters (DW=8, SW=12, NL=3).
module tb_wave_frame_fifo;

    logic        clk;
    logic        rst_n;
    logic [11:0] size_dec;
    logic        wr;
    logic [7:0]  wdata;
    logic        wr_abort;
    logic        rd;
    logic [7:0]  rdata;
    logic        rd_effect;
    logic        rd_last;
    logic        full;
    logic        empty;
    logic [3:0]  frame_cnt;

    int errors = 0;
    int checks = 0;

    wave_frame_fifo #(.DW(8), .SW(12), .NL(3)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_frame_size_dec (size_dec),
        .i_wr             (wr),
        .i_wave_data      (wdata),
        .i_wr_abort       (wr_abort),
        .i_rd             (rd),
        .o_wave_data      (rdata),
        .o_rd_effect      (rd_effect),
        .o_rd_last        (rd_last),
        .o_full           (full),
        .o_empty          (empty),
        .o_frame_cnt      (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  d;
        logic [11:0] sd;
        logic        rd;
        logic        eff;
        logic        last;
        logic [7:0]  data;
        logic        empty;
        logic        full;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic w, input logic [7:0] d, input logic [11:0] sd,
                                input logic r, input logic eff, input logic last,
                                input logic [7:0] data, input logic emp, input logic ful,
                                input logic [3:0] cnt);
        vec_t v;
        v.wr = w; v.d = d; v.sd = sd; v.rd = r;
        v.eff = eff; v.last = last; v.data = data;
        v.empty = emp; v.full = ful; v.cnt = cnt;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs and sample 1 time unit after the rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic [11:0] sd, input logic r);
        wr = w; wdata = d; size_dec = sd; rd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic eff, input logic last,
                              input logic [7:0] data, input logic emp, input logic ful,
                              input logic [3:0] cnt);
        chk({tag, ".rd_effect"}, 32'(rd_effect), 32'(eff));
        chk({tag, ".rd_last"},   32'(rd_last),   32'(last));
        if (eff) chk({tag, ".data"}, 32'(rdata), 32'(data));
        chk({tag, ".empty"},     32'(empty),     32'(emp));
        chk({tag, ".full"},      32'(full),      32'(ful));
        chk({tag, ".cnt"},       32'(frame_cnt), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; wdata = '0; size_dec = '0; wr_abort = 1'b0; rd = 1'b0;
        step(0, 8'h00, 12'd0, 0);
        step(0, 8'h00, 12'd0, 0);
        rst_n = 1'b1;
        step(0, 8'h00, 12'd0, 0);
        expect_out("reset", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
        chk("reset.data", 32'(rdata), 32'h0);

        // Single 4-sample frame, then drain.
        add(1, 8'h10, 12'd3, 0, 0, 0, 8'h00, 1, 0, 4'd0);
        add(1, 8'h11, 12'd3, 0, 0, 0, 8'h00, 1, 0, 4'd0);
        add(1, 8'h12, 12'd3, 0, 0, 0, 8'h00, 1, 0, 4'd0);
        add(1, 8'h13, 12'd3, 0, 0, 0, 8'h00, 0, 0, 4'd1);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h10, 0, 0, 4'd1);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h11, 0, 0, 4'd1);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h12, 0, 0, 4'd1);
        add(0, 8'h00, 12'd0, 1, 1, 1, 8'h13, 1, 0, 4'd0);
        add(0, 8'h00, 12'd0, 0, 0, 0, 8'h00, 1, 0, 4'd0);
        // Frames of 3, 6 and 1 samples; size input changes mid-frame are ignored.
        add(1, 8'h30, 12'd2, 0, 0, 0, 8'h00, 1, 0, 4'd0);
        add(1, 8'h31, 12'd7, 0, 0, 0, 8'h00, 1, 0, 4'd0);
        add(1, 8'h32, 12'd7, 0, 0, 0, 8'h00, 0, 0, 4'd1);
        add(1, 8'h40, 12'd5, 0, 0, 0, 8'h00, 0, 0, 4'd1);
        add(1, 8'h41, 12'd0, 0, 0, 0, 8'h00, 0, 0, 4'd1);
        add(1, 8'h42, 12'd0, 0, 0, 0, 8'h00, 0, 0, 4'd1);
        add(1, 8'h43, 12'd0, 0, 0, 0, 8'h00, 0, 0, 4'd1);
        add(1, 8'h44, 12'd0, 0, 0, 0, 8'h00, 0, 0, 4'd1);
        add(1, 8'h45, 12'd0, 0, 0, 0, 8'h00, 0, 0, 4'd2);
        add(1, 8'h50, 12'd0, 0, 0, 0, 8'h00, 0, 0, 4'd3);
        // Back-to-back drain across frame boundaries.
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h30, 0, 0, 4'd3);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h31, 0, 0, 4'd3);
        add(0, 8'h00, 12'd0, 1, 1, 1, 8'h32, 0, 0, 4'd2);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h40, 0, 0, 4'd2);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h41, 0, 0, 4'd2);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h42, 0, 0, 4'd2);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h43, 0, 0, 4'd2);
        add(0, 8'h00, 12'd0, 1, 1, 0, 8'h44, 0, 0, 4'd2);
        add(0, 8'h00, 12'd0, 1, 1, 1, 8'h45, 0, 0, 4'd1);
        add(0, 8'h00, 12'd0, 1, 1, 1, 8'h50, 1, 0, 4'd0);
        add(0, 8'h00, 12'd0, 1, 0, 0, 8'h00, 1, 0, 4'd0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].wr, vq[i].d, vq[i].sd, vq[i].rd);
            expect_out($sformatf("vec%0d", i), vq[i].eff, vq[i].last, vq[i].data,
                       vq[i].empty, vq[i].full, vq[i].cnt);
        end

        // Fill all 8 slots with 1-sample frames.
        for (int k = 0; k < 8; k++) begin
            step(1, 8'(8'h20 + k), 12'd0, 0);
            expect_out($sformatf("fill%0d", k), 1'b0, 1'b0, 8'h00, 1'b0, (k == 7), 4'(k + 1));
        end
        step(1, 8'hEE, 12'd0, 0);
        expect_out("fill_over", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd8);
        // Read while a write is stalled; the write lands the following cycle.
        step(1, 8'h99, 12'd0, 1);
        expect_out("full_rd", 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 4'd7);
        step(1, 8'h99, 12'd0, 0);
        expect_out("stall_wr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd8);
        for (int k = 0; k < 8; k++) begin
            step(0, 8'h00, 12'd0, 1);
            expect_out($sformatf("drain%0d", k), 1'b1, 1'b1, (k == 7) ? 8'h99 : 8'(8'h21 + k),
                       (k == 7), 1'b0, 4'(7 - k));
        end

        // Simultaneous commit and release with two frames stored.
        step(1, 8'hA0, 12'd1, 0);
        step(1, 8'hA1, 12'd1, 0);
        step(1, 8'hB0, 12'd1, 0);
        step(1, 8'hB1, 12'd1, 0);
        expect_out("two_frames", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd2);
        step(1, 8'hC0, 12'd1, 1);
        expect_out("sim0", 1'b1, 1'b0, 8'hA0, 1'b0, 1'b0, 4'd2);
        step(1, 8'hC1, 12'd1, 1);
        expect_out("sim1", 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 4'd2);
        step(0, 8'h00, 12'd0, 1);
        expect_out("sim_b0", 1'b1, 1'b0, 8'hB0, 1'b0, 1'b0, 4'd2);
        step(0, 8'h00, 12'd0, 1);
        expect_out("sim_b1", 1'b1, 1'b1, 8'hB1, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("sim_c0", 1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("sim_c1", 1'b1, 1'b1, 8'hC1, 1'b1, 1'b0, 4'd0);

`ifdef WAVE_FRAME_FIFO_ABORT_EN
        // Abort a partial 5-word frame, then write a 2-word frame into the same slot.
        step(1, 8'h50, 12'd4, 0);
        step(1, 8'h51, 12'd4, 0);
        step(1, 8'h52, 12'd4, 0);
        wr_abort = 1'b1;
        step(1, 8'h5F, 12'd4, 0);
        wr_abort = 1'b0;
        expect_out("abort", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
        step(1, 8'h60, 12'd1, 0);
        step(1, 8'h61, 12'd1, 0);
        expect_out("abort_commit", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("abort_r0", 1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("abort_r1", 1'b1, 1'b1, 8'h61, 1'b1, 1'b0, 4'd0);
`else
        // Abort pin has no effect in this build.
        step(1, 8'h70, 12'd2, 0);
        wr_abort = 1'b1;
        step(1, 8'h71, 12'd2, 0);
        wr_abort = 1'b0;
        step(1, 8'h72, 12'd2, 0);
        expect_out("noabort_commit", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("noabort_r0", 1'b1, 1'b0, 8'h70, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("noabort_r1", 1'b1, 1'b0, 8'h71, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("noabort_r2", 1'b1, 1'b1, 8'h72, 1'b1, 1'b0, 4'd0);
`endif

        // Reset in the middle of a read with three frames stored.
        for (int k = 0; k < 6; k++) step(1, 8'(k + 1), 12'd1, 0);
        expect_out("pre_rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd3);
        step(0, 8'h00, 12'd0, 1);
        expect_out("pre_rst_rd", 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 4'd3);
        rst_n = 1'b0;
        step(0, 8'h00, 12'd0, 1);
        expect_out("mid_rst", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
        chk("mid_rst.data", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        step(0, 8'h00, 12'd0, 1);
        expect_out("post_rst", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
        step(1, 8'h33, 12'd0, 0);
        expect_out("post_rst_wr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd1);
        step(0, 8'h00, 12'd0, 1);
        expect_out("post_rst_rd", 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
